load_store_unit: RTL

Sequential memory-access controller between the CPU execute stage and Data_Memory. It accepts one load/store request at a time over a valid/ready handshake and sequences Data_Memory's registered read port and write port. Byte stores are done as read-modify-write, and byte loads are zero- or sign-extended to 16 bits. Each request returns exactly one response over a second valid/ready handshake.

---
 rtl/load_store_unit_pkg.sv | 28 ++
 rtl/load_store_unit_byte_lane_formatter.sv | 21 ++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared CPU-side definitions: memory geometry, request encodings and
// the load/store unit's FSM state type.
package CPU_package;

  localparam int DATA_WIDTH        = 16;
  localparam int ADDRESS_WIDTH     = 4;
  // Memory depth in words; addresses at or above this are rejected.
  localparam int ADDRESS_MAX_WIDTH = 12;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic {
    SIZE_WORD = 1'b0,
    SIZE_BYTE = 1'b1
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_byte_lane_formatter.sv
// Byte-lane helper: extracts and extends a byte for loads, and merges a
// new byte into an existing word for read-modify-write stores.
module byte_lane_formatter (
  input  logic [15:0] word,
  input  logic        byte_hi,
  input  logic        is_signed,
  input  logic [7:0]  wdata_byte,
  output logic [15:0] load_data,
  output logic [15:0] store_data
);

  logic [7:0] lane;

  // Select the addressed byte, extend it, and build the merged store word
  always_comb begin
    lane       = byte_hi ? word[15:8] : word[7:0];
    load_data  = is_signed ? {{8{lane[7]}}, lane} : {8'h00, lane};
    store_data = byte_hi ? {wdata_byte, word[7:0]} : {word[15:8], wdata_byte};
  end

endmodule

// File: rtl/load_store_unit.sv
// Serialized load/store controller in front of a memory with a registered
// read port. One request in flight; byte stores use read-modify-write.
module load_store_unit
  import CPU_package::*;
#(
  parameter int DATA_WIDTH        = CPU_package::DATA_WIDTH,
  parameter int ADDRESS_WIDTH     = CPU_package::ADDRESS_WIDTH,
  parameter int ADDRESS_MAX_WIDTH = CPU_package::ADDRESS_MAX_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  mem_op_t                  req_op,
  input  mem_size_t                req_size,
  input  logic                     req_byte_hi,
  input  logic                     req_signed,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic [ADDRESS_WIDTH-1:0] dm_address,
  output logic                     dm_write_enable,
  output logic [DATA_WIDTH-1:0]    dm_data_write,
  output logic                     dm_read_enable,
  input  logic [DATA_WIDTH-1:0]    dm_data_read
);

  // One extra bit so the limit is representable even when the memory
  // fills the whole address space (the error path then never fires).
  localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(ADDRESS_MAX_WIDTH);

  lsu_state_t               state_q, state_d;
  mem_op_t                  op_q, op_d;
  mem_size_t                size_q, size_d;
  logic                     byte_hi_q, byte_hi_d;
  logic                     signed_q, signed_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                     resp_error_q, resp_error_d;
  logic [ADDRESS_WIDTH-1:0] dm_address_q, dm_address_d;
  logic [DATA_WIDTH-1:0]    dm_data_write_q, dm_data_write_d;

  logic                     addr_error;
  logic [DATA_WIDTH-1:0]    fmt_load;
  logic [DATA_WIDTH-1:0]    fmt_store;

  assign addr_error = ({1'b0, req_address} >= ADDR_LIMIT);

  byte_lane_formatter u_formatter (
    .word       (dm_data_read),
    .byte_hi    (byte_hi_q),
    .is_signed  (signed_q),
    .wdata_byte (wdata_q[7:0]),
    .load_data  (fmt_load),
    .store_data (fmt_store)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      op_q            <= MEM_LOAD;
      size_q          <= SIZE_WORD;
      byte_hi_q       <= 1'b0;
      signed_q        <= 1'b0;
      wdata_q         <= '0;
      resp_rdata_q    <= '0;
      resp_error_q    <= 1'b0;
      dm_address_q    <= '0;
      dm_data_write_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      size_q          <= size_d;
      byte_hi_q       <= byte_hi_d;
      signed_q        <= signed_d;
      wdata_q         <= wdata_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_error_q    <= resp_error_d;
      dm_address_q    <= dm_address_d;
      dm_data_write_q <= dm_data_write_d;
    end
  end

  // Next-state and datapath updates; memory-facing address/data only change
  // when a new access is about to be issued so they hold otherwise.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    size_d          = size_q;
    byte_hi_d       = byte_hi_q;
    signed_d        = signed_q;
    wdata_d         = wdata_q;
    resp_rdata_d    = resp_rdata_q;
    resp_error_d    = resp_error_q;
    dm_address_d    = dm_address_q;
    dm_data_write_d = dm_data_write_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d         = req_op;
          size_d       = req_size;
          byte_hi_d    = req_byte_hi;
          signed_d     = req_signed;
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_error_d = addr_error;
          if (addr_error) begin
            state_d = RESP;
          end else begin
            dm_address_d = req_address;
            if (req_op == MEM_STORE && req_size == SIZE_WORD) begin
              dm_data_write_d = req_wdata;
              state_d         = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        if (op_q == MEM_LOAD) begin
          resp_rdata_d = (size_q == SIZE_WORD) ? dm_data_read : fmt_load;
          state_d      = RESP;
        end else begin
          dm_data_write_d = fmt_store;
          state_d         = WRITE;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags and memory strobes decoded from the current state
  always_comb begin
    req_ready       = (state_q == IDLE);
    resp_valid      = (state_q == RESP);
    dm_read_enable  = (state_q == READ);
    dm_write_enable = (state_q == WRITE);
  end

  assign resp_rdata    = resp_rdata_q;
  assign resp_error    = resp_error_q;
  assign dm_address    = dm_address_q;
  assign dm_data_write = dm_data_write_q;

endmodule
